// File: rtl/ws2811_serial.sv
// rtl/ws2811_serial.sv - WS2811/WS2812 single-wire NRZ serialiser for one 24-bit colour word
//
// Purpose:
//   Shifts a latched 24-bit colour word out MSB first as pulse-width encoded
//   bits. Each bit is a high phase followed by a low phase whose lengths
//   depend on the bit value. A one-cycle word_sent strobe follows the low
//   phase of the last bit. The inter-frame latch gap is the caller's job.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   rgb_data   in  24   colour word, bit 23 transmitted first
//   send       in   1   transmit request, level-sensitive, sampled in IDLE only
//   serial     out  1   LED data line (flop output)
//   word_sent  out  1   one-cycle strobe after the final low phase

module ws2811_serial #(
    parameter int T0H = 20,
    parameter int T0L = 43,
    parameter int T1H = 40,
    parameter int T1L = 23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] rgb_data,
    input  logic        send,
    output logic        serial,
    output logic        word_sent
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // The phase counter is loaded with (length - 1) on the edge that enters a
    // phase and the phase ends on the edge where it reads zero, so a phase of
    // length N occupies exactly N clock cycles.
    localparam logic [7:0] T0H_M1 = 8'(T0H - 1);
    localparam logic [7:0] T0L_M1 = 8'(T0L - 1);
    localparam logic [7:0] T1H_M1 = 8'(T1H - 1);
    localparam logic [7:0] T1L_M1 = 8'(T1L - 1);

    logic [1:0]  state;
    logic [4:0]  bit_index;
    logic [7:0]  phase;
    logic [23:0] shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_index <= 5'd0;
            phase     <= 8'd0;
            shift     <= 24'd0;
            serial    <= 1'b0;
            word_sent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    word_sent <= 1'b0;
                    serial    <= 1'b0;
                    if (send) begin
                        shift     <= rgb_data;
                        bit_index <= 5'd23;
                        phase     <= rgb_data[23] ? T1H_M1 : T0H_M1;
                        serial    <= 1'b1;
                        state     <= HIGH;
                    end
                end

                HIGH: begin
                    if (phase == 8'd0) begin
                        serial <= 1'b0;
                        phase  <= shift[23] ? T1L_M1 : T0L_M1;
                        state  <= LOW;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end

                LOW: begin
                    if (phase == 8'd0) begin
                        if (bit_index != 5'd0) begin
                            // shift[22] becomes the current bit after this
                            // shift, so it selects the next high length.
                            bit_index <= bit_index - 5'd1;
                            shift     <= {shift[22:0], 1'b0};
                            phase     <= shift[22] ? T1H_M1 : T0H_M1;
                            serial    <= 1'b1;
                            state     <= HIGH;
                        end else begin
                            word_sent <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end

                DONE: begin
                    word_sent <= 1'b0;
                    serial    <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    serial    <= 1'b0;
                    word_sent <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_serial.sv
// tb/tb_ws2811_serial.sv - self-checking bench for ws2811_serial

module tb_ws2811_serial;

    localparam int T0H = 20;
    localparam int T0L = 43;
    localparam int T1H = 40;
    localparam int T1L = 23;
    localparam int WORD_CYCLES = 1512;

    logic        clock;
    logic        reset;
    logic [23:0] rgb_data;
    logic        send;
    logic        serial;
    logic        word_sent;

    int checks = 0;
    int errors = 0;

    ws2811_serial dut (
        .clock     (clock),
        .reset     (reset),
        .rgb_data  (rgb_data),
        .send      (send),
        .serial    (serial),
        .word_sent (word_sent)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        logic [23:0] data;
        logic [23:0] expect_word;
        int          expect_ones;
        int          change_at;
        logic [23:0] change_val;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called before the start edge: watches one word from the start edge to
    // the IDLE cycle after word_sent, decoding pulse widths and checking them.
    task automatic measure(input logic [23:0] exp_word, input int exp_ones,
                           input bit keep_send, input int change_at,
                           input logic [23:0] change_val);
        int hi = 0;
        int lo = 0;
        int n = 0;
        int ones = 0;
        bit done = 0;
        logic [23:0] dec = 24'd0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clock);
            if (c == 0) begin
                check("start_high", int'(serial), 1);
                if (!keep_send) send = 1'b0;
            end
            if (c == change_at) rgb_data = change_val;
            if (word_sent) begin
                done = 1;
                check("sent_cycle", c, WORD_CYCLES);
                check("last_low", lo, exp_word[0] ? T1L : T0L);
                check("serial_in_done", int'(serial), 0);
            end else if (serial) begin
                if (lo > 0) begin
                    if (n >= 1 && n <= 24)
                        check("low_width", lo, exp_word[24 - n] ? T1L : T0L);
                    lo = 0;
                end
                hi++;
            end else begin
                if (hi > 0) begin
                    if (n < 24) begin
                        check("high_width", hi, exp_word[23 - n] ? T1H : T0H);
                        dec[23 - n] = (hi >= 30);
                    end
                    if (hi >= 30) ones++;
                    n++;
                    hi = 0;
                end
                lo++;
            end
        end
        if (!done) check("word_sent_timeout", 0, 1);
        check("pulse_count", n, 24);
        check("decoded_word", int'(dec), int'(exp_word));
        check("ones_count", ones, exp_ones);
        @(negedge clock);
        check("strobe_one_cycle", int'(word_sent), 0);
        check("idle_serial_low", int'(serial), 0);
    endtask

    task automatic kick(input logic [23:0] d);
        @(negedge clock);
        rgb_data = d;
        send     = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        int bad;
        vecs[0] = '{24'hFF0000, 24'hFF0000,  8,  -1, 24'h0};
        vecs[1] = '{24'h00FF00, 24'h00FF00,  8,  -1, 24'h0};
        vecs[2] = '{24'h0000FF, 24'h0000FF,  8,  -1, 24'h0};
        vecs[3] = '{24'hF0F0F0, 24'hF0F0F0, 12,  -1, 24'h0};
        vecs[4] = '{24'h000000, 24'h000000,  0,  -1, 24'h0};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 24,  -1, 24'h0};
        vecs[6] = '{24'h81AB01, 24'h81AB01,  8, 500, 24'h00FFFF};
        vecs[7] = '{24'h010000, 24'h010000,  1, 100, 24'hFFFFFF};

        reset    = 1'b1;
        send     = 1'b0;
        rgb_data = 24'h0;

        // Reset held 2 us (100 cycles), then idle with send low.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (serial !== 1'b0 || word_sent !== 1'b0) bad++;
        end
        check("reset_outputs", bad, 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (serial !== 1'b0 || word_sent !== 1'b0) bad++;
        end
        check("idle_no_send", bad, 0);

        for (int v = 0; v < 8; v++) begin
            kick(vecs[v].data);
            measure(vecs[v].expect_word, vecs[v].expect_ones, 1'b0,
                    vecs[v].change_at, vecs[v].change_val);
        end

        // send held high: the next word starts right after one IDLE cycle.
        kick(24'hA5C3F0);
        measure(24'hA5C3F0, 12, 1'b1, -1, 24'h0);
        rgb_data = 24'h3C0FF1;
        measure(24'h3C0FF1, 13, 1'b0, -1, 24'h0);

        // Reset in the middle of bit 10 (cycles 630..692).
        kick(24'hFFFFFF);
        for (int c = 0; c <= 650; c++) begin
            @(negedge clock);
            if (c == 0) send = 1'b0;
        end
        check("serial_before_abort", int'(serial), 1);
        reset = 1'b1;
        #1;
        check("abort_serial_low", int'(serial), 0);
        check("abort_no_strobe", int'(word_sent), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clock);
            if (serial !== 1'b0 || word_sent !== 1'b0) bad++;
        end
        check("quiet_after_abort", bad, 0);
        kick(24'h5A5A5A);
        measure(24'h5A5A5A, 12, 1'b0, -1, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
